// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// default data-region offset and grant-index width helper.
package mem_arb_pkg;

  localparam logic [31:0] DATA_PART_OFFSET = 32'h0000_D000;

  typedef enum logic [2:0] {
    IDLE,
    RD_BUSY,
    RD_DONE,
    WR_BUSY,
    WR_DONE
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
// master = arbiter view, slave = caches/memory environment view.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int NUM_RD_PORTS     = 2
);

  logic [NUM_RD_PORTS-1:0]                 i_rd_req;
  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0] i_rd_addr;
  logic [NUM_RD_PORTS-1:0]                 o_rd_done;
  logic [CACHE_LINE_WIDTH-1:0]             o_rd_line;

  logic                  i_wr_valid;
  logic [ADDR_WIDTH-1:0] i_wr_addr;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic [7:0]            i_wr_strobe;
  logic                  o_wr_done;

  logic                        o_mem_read_req;
  logic [ADDR_WIDTH-1:0]       o_mem_read_address;
  logic                        i_mem_read_done;
  logic [CACHE_LINE_WIDTH-1:0] i_cache_line;

  logic                  o_mem_write_valid;
  logic [ADDR_WIDTH-1:0] o_mem_write_address;
  logic [DATA_WIDTH-1:0] o_mem_write_data;
  logic [7:0]            o_write_strobe;
  logic                  i_mem_write_done;

  modport master (
    input  i_rd_req, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data, i_wr_strobe,
    input  i_mem_read_done, i_cache_line, i_mem_write_done,
    output o_rd_done, o_rd_line, o_wr_done,
    output o_mem_read_req, o_mem_read_address,
    output o_mem_write_valid, o_mem_write_address, o_mem_write_data, o_write_strobe
  );

  modport slave (
    output i_rd_req, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data, i_wr_strobe,
    output i_mem_read_done, i_cache_line, i_mem_write_done,
    input  o_rd_done, o_rd_line, o_wr_done,
    input  o_mem_read_req, o_mem_read_address,
    input  o_mem_write_valid, o_mem_write_address, o_mem_write_data, o_write_strobe
  );

endinterface

// File: rtl/mem_arb_picker.sv
// Combinational request picker: scans the request vector starting at 'start'
// (wrapping) and returns the first requester as a one-hot grant and an index.
module mem_arb_picker #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pos = (int'(start) + i) % NUM_PORTS;
      if (!any && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises N cache read ports and one dcache write port onto a single memory channel.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin read grants; default is fixed priority (port 0 first).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                          DATA_WIDTH       = 32,
  parameter int                          ADDR_WIDTH       = 32,
  parameter int                          CACHE_LINE_WIDTH = 256,
  parameter int                          NUM_RD_PORTS     = 2,
  parameter logic [ADDR_WIDTH-1:0]       DATA_BASE        = ADDR_WIDTH'(DATA_PART_OFFSET),
  parameter logic [NUM_RD_PORTS-1:0]     DATA_PORT_MASK   = NUM_RD_PORTS'(2'b10)
) (
  input logic           i_clk,
  input logic           i_rst,
  mem_arbiter_if.master bus
);

  localparam int IDX_W = idx_width(NUM_RD_PORTS);

  arb_state_t              state;
  logic [NUM_RD_PORTS-1:0] grant_oh;
  logic [NUM_RD_PORTS-1:0] pick_grant;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        pick_start;
  logic                    pick_any;
  logic [ADDR_WIDTH-1:0]   pick_addr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;
  assign pick_start = rr_ptr;
`else
  assign pick_start = '0;
`endif

  mem_arb_picker #(
    .NUM_PORTS (NUM_RD_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req   (bus.i_rd_req),
    .start (pick_start),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Data-region ports get the base offset; the sum wraps silently.
  assign pick_addr = bus.i_rd_addr[pick_idx]
                   + ((|(pick_grant & DATA_PORT_MASK)) ? DATA_BASE : '0);

  // One FSM owns every output so the memory side never sees a combinational
  // path from requester inputs; writes are checked before reads in IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                   <= IDLE;
      grant_oh                <= '0;
      bus.o_rd_done           <= '0;
      bus.o_rd_line           <= '0;
      bus.o_wr_done           <= 1'b0;
      bus.o_mem_read_req      <= 1'b0;
      bus.o_mem_read_address  <= '0;
      bus.o_mem_write_valid   <= 1'b0;
      bus.o_mem_write_address <= '0;
      bus.o_mem_write_data    <= '0;
      bus.o_write_strobe      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr                  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_wr_valid) begin
            bus.o_mem_write_address <= bus.i_wr_addr + DATA_BASE;
            bus.o_mem_write_data    <= bus.i_wr_data;
            bus.o_write_strobe      <= bus.i_wr_strobe;
            bus.o_mem_write_valid   <= 1'b1;
            state                   <= WR_BUSY;
          end else if (pick_any) begin
            bus.o_mem_read_address <= pick_addr;
            bus.o_mem_read_req     <= 1'b1;
            grant_oh               <= pick_grant;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_ptr                 <= IDX_W'((int'(pick_idx) + 1) % NUM_RD_PORTS);
`endif
            state                  <= RD_BUSY;
          end
        end
        RD_BUSY: begin
          if (bus.i_mem_read_done) begin
            bus.o_mem_read_req <= 1'b0;
            bus.o_rd_line      <= bus.i_cache_line;
            bus.o_rd_done      <= grant_oh;
            state              <= RD_DONE;
          end
        end
        RD_DONE: begin
          bus.o_rd_done <= '0;
          state         <= IDLE;
        end
        WR_BUSY: begin
          if (bus.i_mem_write_done) begin
            bus.o_mem_write_valid <= 1'b0;
            bus.o_wr_done         <= 1'b1;
            state                 <= WR_DONE;
          end
        end
        WR_DONE: begin
          bus.o_wr_done <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, data-region offset, write priority,
// arbitration order (follows MEM_ARB_ROUND_ROBIN_EN), mid-transfer reset, stray done.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_arbiter_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .CACHE_LINE_WIDTH(256), .NUM_RD_PORTS(2)
  ) bus ();

  mem_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .CACHE_LINE_WIDTH(256), .NUM_RD_PORTS(2),
    .DATA_BASE(32'h0000_D000), .DATA_PORT_MASK(2'b10)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serves one read: drives i_mem_read_done at negedge doneAt, stops when a done pulse appears.
  task automatic runRead(input int doneAt, input logic [255:0] line, input bit keep,
                         output int seen, output int reqAt, output logic [31:0] addr,
                         output logic [1:0] dv);
    seen = 0; reqAt = 0; addr = '0; dv = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (reqAt == 0 && bus.o_mem_read_req) begin
        reqAt = k;
        addr  = bus.o_mem_read_address;
      end
      if (bus.o_rd_done != 0) begin
        seen = k;
        dv   = bus.o_rd_done;
        bus.i_mem_read_done = 1'b0;
        if (!keep) bus.i_rd_req = bus.i_rd_req & ~bus.o_rd_done;
        break;
      end
      bus.i_mem_read_done = (k == doneAt);
      if (k == doneAt) bus.i_cache_line = line;
    end
    bus.i_mem_read_done = 1'b0;
  endtask

  task automatic runWrite(input int doneAt, output int seen, output logic vld, output logic rdq,
                          output logic [31:0] a, output logic [31:0] d, output logic [7:0] s);
    seen = 0; vld = 1'b0; rdq = 1'b0; a = '0; d = '0; s = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        vld = bus.o_mem_write_valid;
        rdq = bus.o_mem_read_req;
        a   = bus.o_mem_write_address;
        d   = bus.o_mem_write_data;
        s   = bus.o_write_strobe;
      end
      if (bus.o_wr_done) begin
        seen = k;
        bus.i_wr_valid       = 1'b0;
        bus.i_mem_write_done = 1'b0;
        break;
      end
      bus.i_mem_write_done = (k == doneAt);
    end
    bus.i_mem_write_done = 1'b0;
  endtask

  initial begin
    int          seen, reqAt;
    logic [31:0] addr, wa, wd;
    logic [1:0]  dv;
    logic        vld, rdq, quiet;
    logic [7:0]  ws;
    logic [1:0]  expGrant [4];
    logic [255:0] lineA, lineB, lineC, lineD;

    total = 0;
    bad   = 0;
    lineA = {8{32'hA5A5_0001}};
    lineB = {8{32'h1234_5678}};
    lineC = {8{32'h0BAD_F00D}};
    lineD = {8{32'h7777_0004}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    expGrant = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    expGrant = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    rst = 1'b1;
    bus.i_rd_req = '0;
    bus.i_rd_addr = '0;
    bus.i_wr_valid = 1'b0;
    bus.i_wr_addr = '0;
    bus.i_wr_data = '0;
    bus.i_wr_strobe = '0;
    bus.i_mem_read_done = 1'b0;
    bus.i_cache_line = '0;
    bus.i_mem_write_done = 1'b0;
    repeat (2) @(negedge clk);

    check("reset_rd_req", bus.o_mem_read_req, 0);
    check("reset_wr_valid", bus.o_mem_write_valid, 0);
    check("reset_rd_done", bus.o_rd_done, 0);
    check("reset_wr_done", bus.o_wr_done, 0);
    check("reset_rd_line", bus.o_rd_line, 0);
    check("reset_rd_addr", bus.o_mem_read_address, 0);
    rst = 1'b0;
    @(negedge clk);

    // Port 0 read of 0x100, no offset; done pulse 4 cycles after the request.
    bus.i_rd_addr[0] = 32'h100;
    bus.i_rd_req = 2'b01;
    runRead(3, lineA, 1'b0, seen, reqAt, addr, dv);
    check("p0_req_delay", reqAt, 1);
    check("p0_addr", addr, 32'h100);
    check("p0_latency", seen, 4);
    check("p0_done_vec", dv, 2'b01);
    check("p0_line", bus.o_rd_line, lineA);
    @(negedge clk);
    check("p0_pulse_one_cycle", bus.o_rd_done, 0);
    check("p0_line_held", bus.o_rd_line, lineA);

    // Port 1 is a data port: 0x40 becomes 0xD040.
    bus.i_rd_addr[1] = 32'h40;
    bus.i_rd_req = 2'b10;
    runRead(3, lineB, 1'b0, seen, reqAt, addr, dv);
    check("p1_addr", addr, 32'hD040);
    check("p1_done_vec", dv, 2'b10);
    check("p1_line", bus.o_rd_line, lineB);
    @(negedge clk);

    // Write and port-0 read together: write goes first.
    bus.i_wr_addr = 32'h20;
    bus.i_wr_data = 32'hDEAD_BEEF;
    bus.i_wr_strobe = 8'h0F;
    bus.i_wr_valid = 1'b1;
    bus.i_rd_addr[0] = 32'h300;
    bus.i_rd_req = 2'b01;
    runWrite(2, seen, vld, rdq, wa, wd, ws);
    check("wr_valid_first", vld, 1'b1);
    check("wr_beats_read", rdq, 1'b0);
    check("wr_addr", wa, 32'hD020);
    check("wr_data", wd, 32'hDEAD_BEEF);
    check("wr_strobe", ws, 8'h0F);
    check("wr_done_latency", seen, 3);
    runRead(4, lineC, 1'b0, seen, reqAt, addr, dv);
    check("rd_after_wr_addr", addr, 32'h300);
    check("rd_after_wr_done", dv, 2'b01);
    check("rd_after_wr_line", bus.o_rd_line, lineC);
    @(negedge clk);
    check("wr_pulse_cleared", bus.o_wr_done, 0);

    // Reset while RD_BUSY: everything clears at once, no done pulse follows.
    bus.i_rd_addr[0] = 32'h80;
    bus.i_rd_req = 2'b01;
    @(negedge clk);
    check("rst_busy_req", bus.o_mem_read_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_req", bus.o_mem_read_req, 0);
    check("rst_async_addr", bus.o_mem_read_address, 0);
    check("rst_async_line", bus.o_rd_line, 0);
    bus.i_rd_req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.o_rd_done != 0 || bus.o_mem_read_req) quiet = 1'b0;
    end
    check("rst_no_done", quiet, 1'b1);
    bus.i_rd_addr[1] = 32'h10;
    bus.i_rd_req = 2'b10;
    runRead(3, lineD, 1'b0, seen, reqAt, addr, dv);
    check("post_rst_addr", addr, 32'hD010);
    check("post_rst_done", dv, 2'b10);

    // Both ports requesting continuously.
    bus.i_rd_addr[0] = 32'h400;
    bus.i_rd_addr[1] = 32'h500;
    bus.i_rd_req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      runRead(3, lineA, 1'b1, seen, reqAt, addr, dv);
      check($sformatf("arb_grant_%0d", n), dv, expGrant[n]);
      check($sformatf("arb_addr_%0d", n), addr, (expGrant[n] == 2'b01) ? 32'h400 : 32'hD500);
    end
    bus.i_rd_req = 2'b00;
    repeat (2) @(negedge clk);

    // Stray memory done strobes while IDLE are ignored.
    bus.i_cache_line = lineB;
    bus.i_mem_read_done = 1'b1;
    bus.i_mem_write_done = 1'b1;
    @(negedge clk);
    bus.i_mem_read_done = 1'b0;
    bus.i_mem_write_done = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.o_rd_done != 0 || bus.o_wr_done || bus.o_mem_read_req || bus.o_mem_write_valid)
        quiet = 1'b0;
    end
    check("idle_stray_done", quiet, 1'b1);
    check("idle_line_kept", bus.o_rd_line, lineA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised arbiter between N cache read requesters plus one data-cache write port and the single external memory read/write channel. It generalises the fixed two-port icache/dcache translator. Reads and writes are serialised through one FSM, and every requester gets a registered one-cycle done pulse. A per-port data-region base offset is applied to addresses, and arbitration is either round-robin or fixed priority. It sits between the L1 caches and the memory controller.

## Interface
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 32, address width
- CACHE_LINE_WIDTH, 256, read line width
- NUM_RD_PORTS, 2, read requesters (≥1); port 0 = icache by convention
- DATA_BASE, 32'h0000_D000, offset added to data-region addresses
- DATA_PORT_MASK, 2'b10, bit p=1 → DATA_BASE added to read port p's address
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_rd_req  in  NUM_RD_PORTS  per-port read request, level, held until done
- i_rd_addr  in  NUM_RD_PORTS×ADDR_WIDTH  per-port read address
- o_rd_done  out  NUM_RD_PORTS  one-hot one-cycle done pulse
- o_rd_line  out  CACHE_LINE_WIDTH  registered returned line, valid when any o_rd_done
- i_wr_valid  in  1  dcache write request, level, held until o_wr_done
- i_wr_addr / i_wr_data / i_wr_strobe  in  ADDR_WIDTH / DATA_WIDTH / 8  write payload
- o_wr_done  out  1  one-cycle write done pulse
- o_mem_read_req / o_mem_read_address  out  1 / ADDR_WIDTH  memory read channel
- i_mem_read_done / i_cache_line  in  1 / CACHE_LINE_WIDTH  memory read return
- o_mem_write_valid / o_mem_write_address / o_mem_write_data / o_write_strobe  out  1 / ADDR_WIDTH / DATA_WIDTH / 8  memory write channel
- i_mem_write_done  in  1  memory write ack

## Operation
- FSM states: IDLE, RD_BUSY, RD_DONE, WR_BUSY, WR_DONE.
- IDLE: if i_wr_valid, latch write payload (address + DATA_BASE) and go to WR_BUSY. Pending writes beat reads. Else, if any i_rd_req, grant one port, latch its address (+DATA_BASE if its mask bit is set) and the grant index, and go to RD_BUSY.
- RD_BUSY: o_mem_read_req=1 with the latched address. On i_mem_read_done, capture i_cache_line into o_rd_line and go to RD_DONE.
- RD_DONE: o_rd_done[grant]=1 for exactly one cycle, then IDLE.
- WR_BUSY: o_mem_write_valid=1 with the latched payload. On i_mem_write_done, go to WR_DONE.
- WR_DONE: o_wr_done=1 for one cycle, then IDLE.
- Memory done inputs outside their BUSY state are ignored.
- A requester that drops its request while BUSY does not abort the transfer; its done pulse still fires.
- Address arithmetic is modulo 2^ADDR_WIDTH, and wrap is silent.
- o_rd_line holds its value until the next capture.

## Timing
- Reset (async assert, sync release): state=IDLE, all outputs 0, o_rd_line=0, RR pointer=0.
- Reset mid-transfer abandons the transfer, and no done pulse is issued.
- Read: request seen in IDLE at cycle 0 → o_mem_read_req in cycle 1 → i_mem_read_done in cycle m≥1 → o_rd_done and o_rd_line in cycle m+1 → IDLE in cycle m+2. The minimum latency is 2 cycles from request to done.
- Write: same shape as read; o_wr_done arrives one cycle after i_mem_write_done.
- Requesters must deassert their request in the cycle after their done pulse. Otherwise the request is re-arbitrated as a new one.
- Memory-side outputs are registered; no combinational path exists from requester inputs to memory outputs.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: the read grant searches from (last_grant+1) mod NUM_RD_PORTS upward. The pointer updates on each grant.
- Undefined: fixed priority, and the lowest index wins (icache first). There is no pointer register.

## Structure
- mem_arb_pkg: the FSM state enum and the DATA_PART_OFFSET default constant (32'h0000_D000).
- Sub-module mem_arb_picker: combinational, takes the request vector and start index and returns a one-hot grant plus its index. The macro selects its start input.

## Test plan
- Single port-0 read of 0x100, memory done 3 cycles after o_mem_read_req → o_mem_read_address=0x100; o_rd_done[0] pulses for 1 cycle with the line; total latency 4 cycles.
- Port-1 read of 0x40 → o_mem_read_address=0xD040; only o_rd_done[1] pulses.
- Write 0x20, data 0xDEADBEEF, strobe 0x0F while port 0 also requests → the write is issued first at 0xD020 and o_wr_done pulses; then the port-0 read is served.
- Ports 0 and 1 both requesting continuously, MEM_ARB_ROUND_ROBIN_EN defined → grants alternate 0,1,0,1. With the macro undefined → port 0 is always granted.
- i_rst asserted in RD_BUSY → all outputs 0 immediately and no o_rd_done; after release, a new request completes normally.
- i_mem_read_done pulsed while IDLE → no state change and no done pulse.
